clif_neuron_array_engine: RTL and testbench

Time-multiplexed conductance-based LIF engine. One update datapath is shared across NUM_NEURONS neurons, with per-neuron status held in internal registers. It adds adaptive thresholds (theta) and a weight-sum fetch handshake. It sits between the synaptic weight-sum accumulator and the spike router: one StepStart advances every neuron by one DeltaT.

---
 rtl/clif_neuron_array_engine.sv | 245 ++++++++++++++++++++++++
 tb/tb_clif_neuron_array_engine.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clif_neuron_array_engine.sv
`default_nettype none
// ============================================================================
// Module   : clif_neuron_array_engine
// Purpose  : Time-multiplexed conductance-based LIF engine with adaptive
//            thresholds. One shared update datapath walks every neuron once
//            per StepStart, fetching weight sums and writing back status.
// Revision : 1.0 - initial release
// ============================================================================
module clif_neuron_array_engine #(
    parameter int NUM_NEURONS     = 16,
    parameter int ADDR_WIDTH      = 4,
    parameter int INTEGER_WIDTH   = 32,
    parameter int DATA_WIDTH_FRAC = 32,
    parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int TREF_WIDTH      = 5,
    parameter int REST_V          = -65,
    parameter int RESET_V         = -65,
    parameter int EX_REV          = 0,
    parameter int IN_REV          = -100,
    parameter int THRESHOLD       = -52,
    parameter int REFRACTORY      = 10,
    parameter int TAUM_SHIFT      = 7,
    parameter int GEX_SHIFT       = 1,
    parameter int GIN_SHIFT       = 2,
    parameter int THETA_SHIFT     = 10,
    parameter int THETA_INC       = 1 << 24
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Initialize,
    input  logic                         StepStart,
    output logic                         Busy,
    output logic                         StepDone,
    output logic                         WtReq,
    output logic [ADDR_WIDTH-1:0]        WtAddr,
    input  logic                         WtValid,
    input  logic signed [DATA_WIDTH-1:0] ExWeightSum,
    input  logic signed [DATA_WIDTH-1:0] InWeightSum,
    output logic                         SpikeValid,
    output logic [ADDR_WIDTH-1:0]        SpikeAddr,
    output logic                         WbValid,
    output logic [ADDR_WIDTH-1:0]        WbAddr,
    output logic signed [DATA_WIDTH-1:0] WbVmem
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam logic signed [DATA_WIDTH-1:0] C_REST_V    = DATA_WIDTH'(REST_V) <<< DATA_WIDTH_FRAC;
    localparam logic signed [DATA_WIDTH-1:0] C_RESET_V   = DATA_WIDTH'(RESET_V) <<< DATA_WIDTH_FRAC;
    localparam logic signed [DATA_WIDTH-1:0] C_EX_REV    = DATA_WIDTH'(EX_REV) <<< DATA_WIDTH_FRAC;
    localparam logic signed [DATA_WIDTH-1:0] C_IN_REV    = DATA_WIDTH'(IN_REV) <<< DATA_WIDTH_FRAC;
    localparam logic signed [DATA_WIDTH-1:0] C_THRESHOLD = DATA_WIDTH'(THRESHOLD) <<< DATA_WIDTH_FRAC;
    localparam logic signed [DATA_WIDTH-1:0] C_THETA_INC = DATA_WIDTH'(THETA_INC);
    localparam logic [TREF_WIDTH-1:0]        C_REF       = TREF_WIDTH'(REFRACTORY);
    localparam logic [ADDR_WIDTH-1:0]        C_LAST      = ADDR_WIDTH'(NUM_NEURONS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_FETCH  = 3'd2,
        S_UPDATE = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                         r_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0]          r_idx_q, w_idx_d;
    logic signed [DATA_WIDTH-1:0]   r_ex_q, w_ex_d, r_in_q, w_in_d;
    logic signed [DATA_WIDTH-1:0]   r_res_v_q, w_res_v_d, r_res_gex_q, w_res_gex_d;
    logic signed [DATA_WIDTH-1:0]   r_res_gin_q, w_res_gin_d, r_res_th_q, w_res_th_d;
    logic [TREF_WIDTH-1:0]          r_res_ref_q, w_res_ref_d;
    logic                           r_res_spk_q, w_res_spk_d;

    // Per-neuron status storage and the single write port into it
    logic signed [DATA_WIDTH-1:0]   r_vmem_q [NUM_NEURONS];
    logic signed [DATA_WIDTH-1:0]   r_gex_q  [NUM_NEURONS];
    logic signed [DATA_WIDTH-1:0]   r_gin_q  [NUM_NEURONS];
    logic signed [DATA_WIDTH-1:0]   r_theta_q[NUM_NEURONS];
    logic [TREF_WIDTH-1:0]          r_ref_q  [NUM_NEURONS];
    logic                           w_wr_en;
    logic signed [DATA_WIDTH-1:0]   w_vmem_d, w_gex_d, w_gin_d, w_theta_d;
    logic [TREF_WIDTH-1:0]          w_ref_d;

    // Datapath intermediates for the neuron currently selected by r_idx_q
    logic signed [DATA_WIDTH-1:0]   w_cur_v, w_cur_gex, w_cur_gin, w_cur_th;
    logic [TREF_WIDTH-1:0]          w_cur_ref;
    logic signed [DATA_WIDTH-1:0]   w_gex_n, w_gin_n, w_th_dec, w_dex, w_din;
    logic signed [PW-1:0]           w_prod_ex, w_prod_in;
    logic signed [DATA_WIDTH-1:0]   w_pex_t, w_pin_t, w_v_int, w_v_n, w_th_n;
    logic [TREF_WIDTH-1:0]          w_ref_n;
    logic                           w_fire;

    // Shared neuron update: conductance decay, membrane integration, spike test
    always_comb begin
        w_cur_v   = r_vmem_q[r_idx_q];
        w_cur_gex = r_gex_q[r_idx_q];
        w_cur_gin = r_gin_q[r_idx_q];
        w_cur_th  = r_theta_q[r_idx_q];
        w_cur_ref = r_ref_q[r_idx_q];
        w_gex_n   = w_cur_gex + r_ex_q - (w_cur_gex >>> GEX_SHIFT);
        w_gin_n   = w_cur_gin + r_in_q - (w_cur_gin >>> GIN_SHIFT);
        w_th_dec  = w_cur_th - (w_cur_th >>> THETA_SHIFT);
        w_dex     = C_EX_REV - w_cur_v;
        w_din     = C_IN_REV - w_cur_v;
        // Full-width products; the window at the fraction point is kept
        w_prod_ex = PW'(w_gex_n) * PW'(w_dex);
        w_prod_in = PW'(w_gin_n) * PW'(w_din);
        w_pex_t   = DATA_WIDTH'(w_prod_ex >>> DATA_WIDTH_FRAC);
        w_pin_t   = DATA_WIDTH'(w_prod_in >>> DATA_WIDTH_FRAC);
        w_v_int   = w_cur_v + ((C_REST_V - w_cur_v) >>> TAUM_SHIFT)
                    + (w_pex_t >>> TAUM_SHIFT) + (w_pin_t >>> TAUM_SHIFT);
        w_fire    = (w_cur_ref == '0) && (w_v_int >= (C_THRESHOLD + w_th_dec));
        w_v_n     = ((w_cur_ref != '0) || w_fire) ? C_RESET_V : w_v_int;
        w_ref_n   = (w_cur_ref != '0) ? (w_cur_ref - TREF_WIDTH'(1))
                                      : (w_fire ? C_REF : '0);
        w_th_n    = w_fire ? (w_th_dec + C_THETA_INC) : w_th_dec;
    end

    // Next-state, sequencing and status write-port control
    always_comb begin
        w_state_d   = r_state_q;
        w_idx_d     = r_idx_q;
        w_ex_d      = r_ex_q;
        w_in_d      = r_in_q;
        w_res_v_d   = r_res_v_q;
        w_res_gex_d = r_res_gex_q;
        w_res_gin_d = r_res_gin_q;
        w_res_th_d  = r_res_th_q;
        w_res_ref_d = r_res_ref_q;
        w_res_spk_d = r_res_spk_q;
        w_wr_en     = 1'b0;
        w_vmem_d    = C_REST_V;
        w_gex_d     = '0;
        w_gin_d     = '0;
        w_theta_d   = '0;
        w_ref_d     = '0;
        case (r_state_q)
            S_IDLE: begin
                w_idx_d = '0;
                if (Initialize)     w_state_d = S_INIT;
                else if (StepStart) w_state_d = S_FETCH;
            end
            S_INIT: begin
                w_wr_en = 1'b1;
                if (r_idx_q == C_LAST) begin
                    w_idx_d   = '0;
                    w_state_d = S_IDLE;
                end else begin
                    w_idx_d   = r_idx_q + ADDR_WIDTH'(1);
                end
            end
            S_FETCH: begin
                if (WtValid) begin
                    w_ex_d    = ExWeightSum;
                    w_in_d    = InWeightSum;
                    w_state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                w_res_v_d   = w_v_n;
                w_res_gex_d = w_gex_n;
                w_res_gin_d = w_gin_n;
                w_res_th_d  = w_th_n;
                w_res_ref_d = w_ref_n;
                w_res_spk_d = w_fire;
                w_state_d   = S_WRITE;
            end
            S_WRITE: begin
                w_wr_en   = 1'b1;
                w_vmem_d  = r_res_v_q;
                w_gex_d   = r_res_gex_q;
                w_gin_d   = r_res_gin_q;
                w_theta_d = r_res_th_q;
                w_ref_d   = r_res_ref_q;
                if (r_idx_q == C_LAST) begin
                    w_idx_d   = '0;
                    w_state_d = S_DONE;
                end else begin
                    w_idx_d   = r_idx_q + ADDR_WIDTH'(1);
                    w_state_d = S_FETCH;
                end
            end
            S_DONE:  w_state_d = S_IDLE;
            default: w_state_d = S_IDLE;
        endcase
    end

    // Control and pipeline registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state_q   <= S_IDLE;
            r_idx_q     <= '0;
            r_ex_q      <= '0;
            r_in_q      <= '0;
            r_res_v_q   <= '0;
            r_res_gex_q <= '0;
            r_res_gin_q <= '0;
            r_res_th_q  <= '0;
            r_res_ref_q <= '0;
            r_res_spk_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_idx_q     <= w_idx_d;
            r_ex_q      <= w_ex_d;
            r_in_q      <= w_in_d;
            r_res_v_q   <= w_res_v_d;
            r_res_gex_q <= w_res_gex_d;
            r_res_gin_q <= w_res_gin_d;
            r_res_th_q  <= w_res_th_d;
            r_res_ref_q <= w_res_ref_d;
            r_res_spk_q <= w_res_spk_d;
        end
    end

    // Neuron status array, one entry written per cycle at r_idx_q
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_vmem_q[i]  <= C_REST_V;
                r_gex_q[i]   <= '0;
                r_gin_q[i]   <= '0;
                r_theta_q[i] <= '0;
                r_ref_q[i]   <= '0;
            end
        end else if (w_wr_en) begin
            r_vmem_q[r_idx_q]  <= w_vmem_d;
            r_gex_q[r_idx_q]   <= w_gex_d;
            r_gin_q[r_idx_q]   <= w_gin_d;
            r_theta_q[r_idx_q] <= w_theta_d;
            r_ref_q[r_idx_q]   <= w_ref_d;
        end
    end

    // Outputs decode registered state only, so they are glitch-free
    assign Busy       = (r_state_q != S_IDLE);
    assign StepDone   = (r_state_q == S_DONE);
    assign WtReq      = (r_state_q == S_FETCH);
    assign WtAddr     = (r_state_q == S_FETCH) ? r_idx_q : '0;
    assign WbValid    = (r_state_q == S_WRITE);
    assign WbAddr     = (r_state_q == S_WRITE) ? r_idx_q : '0;
    assign WbVmem     = (r_state_q == S_WRITE) ? r_res_v_q : '0;
    assign SpikeValid = (r_state_q == S_WRITE) && r_res_spk_q;
    assign SpikeAddr  = ((r_state_q == S_WRITE) && r_res_spk_q) ? r_idx_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_clif_neuron_array_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_clif_neuron_array_engine
// Purpose  : Directed self-checking bench with a fixed-point neuron model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clif_neuron_array_engine;

    localparam int N = 16;

    logic               Clock, Reset, Initialize, StepStart, WtValid;
    logic               Busy, StepDone, WtReq, SpikeValid, WbValid;
    logic [3:0]         WtAddr, SpikeAddr, WbAddr;
    logic signed [63:0] ExWeightSum, InWeightSum, WbVmem;

    clif_neuron_array_engine dut (
        .Clock(Clock), .Reset(Reset), .Initialize(Initialize), .StepStart(StepStart),
        .Busy(Busy), .StepDone(StepDone), .WtReq(WtReq), .WtAddr(WtAddr),
        .WtValid(WtValid), .ExWeightSum(ExWeightSum), .InWeightSum(InWeightSum),
        .SpikeValid(SpikeValid), .SpikeAddr(SpikeAddr), .WbValid(WbValid),
        .WbAddr(WbAddr), .WbVmem(WbVmem)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_vec, n_err, cyc, done_cnt, spk_cnt, last_spk;
    logic signed [63:0] v0_seen;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model -----------------------------------
    typedef struct { int addr; logic signed [63:0] v; bit spike; } exp_t;
    exp_t expq[$];
    logic signed [63:0] m_v[N], m_gex[N], m_gin[N], m_th[N];
    int                 m_ref[N];
    logic signed [63:0] ex_tab[N], in_tab[N];

    // Integer millivolts to Q32.32
    function automatic logic signed [63:0] fx(input int mv);
        return longint'(mv) * 64'sd4294967296;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = fx(-65); m_gex[i] = 0; m_gin[i] = 0; m_th[i] = 0; m_ref[i] = 0;
        end
    endfunction

    function automatic void model_neuron(input int n, input logic signed [63:0] ex,
                                         input logic signed [63:0] inh);
        logic signed [63:0]  ge, gi, th, v, vn;
        logic signed [127:0] pe, pi;
        exp_t e;
        ge = m_gex[n] + ex - (m_gex[n] >>> 1);
        gi = m_gin[n] + inh - (m_gin[n] >>> 2);
        th = m_th[n] - (m_th[n] >>> 10);
        v  = m_v[n];
        e.spike = 1'b0;
        if (m_ref[n] > 0) begin
            vn = fx(-65);
            m_ref[n] = m_ref[n] - 1;
        end else begin
            pe = ge * (fx(0) - v);
            pi = gi * (fx(-100) - v);
            vn = v + ((fx(-65) - v) >>> 7) + ($signed(pe[95:32]) >>> 7)
                   + ($signed(pi[95:32]) >>> 7);
            if (vn >= fx(-52) + th) begin
                e.spike  = 1'b1;
                vn       = fx(-65);
                m_ref[n] = 10;
                th       = th + 64'sd16777216;
            end
        end
        m_v[n] = vn; m_gex[n] = ge; m_gin[n] = gi; m_th[n] = th;
        e.addr = n; e.v = vn;
        expq.push_back(e);
    endfunction

    // ---------------- compare process -------------------------------------
    always @(negedge Clock) begin
        if (!Reset) begin
            if (WbValid) begin
                if (expq.size() == 0) begin
                    check("wb_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("wb_addr", WbAddr, e.addr);
                    check("wb_vmem", WbVmem, e.v);
                    check("spike_valid", SpikeValid, e.spike);
                    if (e.spike) check("spike_addr", SpikeAddr, e.addr);
                end
                if (SpikeValid) begin spk_cnt++; last_spk = SpikeAddr; end
                if (WbAddr == 4'd0) v0_seen = WbVmem;
            end else if (SpikeValid) begin
                check("spike_without_wb", 1, 0);
            end
            if (StepDone) done_cnt++;
        end
    end

    // ---------------- stimulus --------------------------------------------
    task automatic clear_tabs();
        for (int i = 0; i < N; i++) begin ex_tab[i] = 0; in_tab[i] = 0; end
    endtask

    task automatic run_step(input int hold_n, input int hold_cyc, input int exp_len);
        int c0, t;
        c0 = cyc;
        @(negedge Clock) StepStart = 1'b1;
        @(negedge Clock) StepStart = 1'b0;
        for (int n = 0; n < N; n++) begin
            t = 0;
            while (!WtReq && t < 20) begin @(negedge Clock); t++; end
            if (!WtReq) check("wtreq_timeout", 0, 1);
            if (n == 0) c0 = cyc;
            check("wt_addr", WtAddr, n);
            ExWeightSum = ex_tab[n];
            InWeightSum = in_tab[n];
            if (n == hold_n) begin
                WtValid = 1'b0;
                repeat (hold_cyc) begin
                    @(negedge Clock);
                    check("hold_req_addr_wb", {WtReq, WtAddr, WbValid}, {1'b1, 4'(n), 1'b0});
                end
                WtValid = 1'b1;
            end
            if (n == 5) StepStart = 1'b1;   // must be dropped while Busy
            model_neuron(n, ex_tab[n], in_tab[n]);
            @(negedge Clock);
            StepStart = 1'b0;
            check("wtreq_drop", WtReq, 0);
        end
        t = 0;
        while (!StepDone && t < 20) begin @(negedge Clock); t++; end
        check("step_len", cyc - c0 + 1, exp_len);
        repeat (3) begin
            @(negedge Clock);
            check("idle_after_done", {Busy, WtReq}, 0);
        end
        check("queue_drained", expq.size(), 0);
    endtask

    initial begin
        int cnt, d0;
        Reset = 1'b1; Initialize = 1'b0; StepStart = 1'b0; WtValid = 1'b1;
        ExWeightSum = 0; InWeightSum = 0; v0_seen = 0;
        model_reset(); clear_tabs();
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check("reset_outputs", {Busy, StepDone, WtReq, WtAddr, SpikeValid, SpikeAddr, WbValid, WbAddr}, 0);
        check("reset_wbvmem", WbVmem, 0);

        // All-zero step: every neuron stays at -65 mV, 49 cycles
        spk_cnt = 0;
        run_step(-1, 0, 49);
        check("zero_step_spikes", spk_cnt, 0);

        // Neuron 3 driven hard: V' = -32.5 mV crosses -52 mV
        ex_tab[3] = fx(64);
        spk_cnt = 0;
        run_step(-1, 0, 49);
        check("step1_spikes", spk_cnt, 1);
        check("step1_spike_addr", last_spk, 3);

        // Refractory steps 2..11: no spikes
        spk_cnt = 0;
        for (int s = 2; s <= 11; s++) run_step(-1, 0, 49);
        check("refractory_spikes", spk_cnt, 0);

        // Step 12 spikes again; theta carries two increments less decay
        spk_cnt = 0;
        run_step(-1, 0, 49);
        check("step12_spikes", spk_cnt, 1);
        check("step12_spike_addr", last_spk, 3);
        check("theta_window", (m_th[3] > 64'sd32505856) && (m_th[3] < 64'sd33554432), 1);

        // Inhibition on neuron 0 (-67.1875 mV) with a 5-cycle stall on neuron 2
        clear_tabs();
        in_tab[0] = fx(8);
        run_step(2, 5, 54);
        check("v0_literal", v0_seen, -64'sd288568115200);
        check("v0_model_literal", m_v[0], -64'sd288568115200);

        // Initialize (wins over StepStart): 16 Busy cycles, no StepDone, no WtReq
        d0 = done_cnt;
        @(negedge Clock) begin Initialize = 1'b1; StepStart = 1'b1; end
        @(negedge Clock) begin Initialize = 1'b0; StepStart = 1'b0; end
        cnt = 0;
        while (Busy && cnt < 60) begin
            if (WtReq) check("wtreq_in_init", 1, 0);
            cnt++;
            @(negedge Clock);
        end
        check("init_busy_cycles", cnt, 16);
        check("init_no_stepdone", done_cnt, d0);
        model_reset();

        clear_tabs();
        spk_cnt = 0;
        run_step(-1, 0, 49);
        check("post_init_spikes", spk_cnt, 0);

        // Disturb neuron 0 again, then abort a step with Reset at cycle 10
        in_tab[0] = fx(8);
        run_step(-1, 0, 49);
        clear_tabs();
        ExWeightSum = 0; InWeightSum = 0;
        d0 = done_cnt;
        for (int n = 0; n < 3; n++) model_neuron(n, 0, 0);
        @(negedge Clock) StepStart = 1'b1;
        @(negedge Clock) StepStart = 1'b0;
        repeat (9) @(negedge Clock);
        Reset = 1'b1;
        #1;
        check("reset_mid_step_outputs", {Busy, WtReq, WbValid, StepDone}, 0);
        expq.delete();
        model_reset();
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check("reset_no_stepdone", done_cnt, d0);
        check("reset_idle", Busy, 0);

        // State must be back at rest: neuron 0 returns exactly -65 mV
        run_step(-1, 0, 49);
        check("post_reset_v0", v0_seen, -64'sd279172874240);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
